// File: rtl/spi_slave_fsm.sv
// SPI slave transaction engine: decodes an address + R/W command, then writes
// one byte to memory or shifts one byte out on MISO.
module spi_slave_fsm #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_n,
  input  logic                  sclk_pe,
  input  logic                  sclk_ne,
  input  logic                  mosi,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  miso,
  output logic                  miso_oe,
  output logic                  xfer_done
);

  localparam int unsigned CmdWidth   = ADDR_WIDTH + 1;
  localparam int unsigned ShiftWidth = (CmdWidth > DATA_WIDTH) ? CmdWidth : DATA_WIDTH;
  localparam int unsigned CntWidth   = $clog2(ShiftWidth + 1);

  typedef enum logic [2:0] {
    StIdle,
    StGetCmd,
    StReadLoad,
    StReadShift,
    StWriteShift,
    StWriteCommit,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  // Holds the bits received so far; the newest bit comes straight from mosi,
  // so shift_in is the full ShiftWidth-bit shift register value.
  logic [ShiftWidth-2:0] shift_q, shift_d;
  logic [ShiftWidth-1:0] shift_in;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  miso_q, miso_d;

  assign shift_in = {shift_q, mosi};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    out_d   = out_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    miso_d  = miso_q;
    we_d    = 1'b0;
    done_d  = 1'b0;

    if (cs_n) begin
      state_d = StIdle;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d   = '0;
          state_d = StGetCmd;
        end
        StGetCmd: begin
          if (sclk_pe) begin
            shift_d = shift_in[ShiftWidth-2:0];
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CntWidth'(CmdWidth - 1)) begin
              addr_d  = shift_in[CmdWidth-1:1];
              cnt_d   = '0;
              state_d = shift_in[0] ? StReadLoad : StWriteShift;
            end
          end
        end
        StReadLoad: begin
          out_d   = mem_rdata;
          state_d = StReadShift;
        end
        StReadShift: begin
          // A coincident falling-edge pulse loses to the rising edge.
          if (sclk_pe) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntWidth'(DATA_WIDTH - 1)) begin
              cnt_d   = '0;
              done_d  = 1'b1;
              state_d = StDone;
            end
          end else if (sclk_ne) begin
            miso_d = out_q[DATA_WIDTH-1];
            out_d  = {out_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
        StWriteShift: begin
          if (sclk_pe) begin
            shift_d = shift_in[ShiftWidth-2:0];
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CntWidth'(DATA_WIDTH - 1)) begin
              cnt_d   = '0;
              wdata_d = shift_in[DATA_WIDTH-1:0];
              we_d    = 1'b1;
              done_d  = 1'b1;
              state_d = StWriteCommit;
            end
          end
        end
        StWriteCommit: state_d = StDone;
        StDone:        state_d = StDone;
        default:       state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      out_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      miso_q  <= miso_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign xfer_done = done_q;
  assign miso      = miso_q;
  assign miso_oe   = (state_q == StReadShift);

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Randomized bench for spi_slave_fsm against a byte-array memory model that
// tracks which frames complete and what each read must return.
module tb_spi_slave_fsm;

  logic       clk = 1'b0;
  logic       rst_n, cs_n, sclk_pe, sclk_ne, mosi;
  logic [7:0] mem_rdata, mem_wdata;
  logic [6:0] mem_addr;
  logic       mem_we, miso, miso_oe, xfer_done;

  always #5 clk = ~clk;

  spi_slave_fsm #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_n      (cs_n),
    .sclk_pe   (sclk_pe),
    .sclk_ne   (sclk_ne),
    .mosi      (mosi),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .xfer_done (xfer_done)
  );

  // Environment memory driven by the DUT; exp_mem is the reference contents.
  logic [7:0] env_mem [128];
  logic [7:0] exp_mem [128];
  logic       pl_en;
  logic [6:0] pl_addr;
  logic [7:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) env_mem[pl_addr] <= pl_data;
    else if (mem_we) env_mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = env_mem[mem_addr];

  int         we_tot, done_tot, oe_tot, consec_tot;
  logic       prev_we, prev_done;
  logic [6:0] we_addr;
  logic [7:0] we_data;

  always @(negedge clk) begin
    if (mem_we) begin
      we_tot  <= we_tot + 1;
      we_addr <= mem_addr;
      we_data <= mem_wdata;
    end
    if (xfer_done) done_tot <= done_tot + 1;
    if (miso_oe) oe_tot <= oe_tot + 1;
    if ((mem_we && prev_we === 1'b1) || (xfer_done && prev_done === 1'b1))
      consec_tot <= consec_tot + 1;
    prev_we   <= mem_we;
    prev_done <= xfer_done;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One SPI bit: falling edge, gap, rising edge (MISO sampled here), gap.
  task automatic send_bit(input logic b, output logic m, output logic oe);
    mosi    = b;
    sclk_ne = 1'b1;
    tick();
    sclk_ne = 1'b0;
    repeat (3) tick();
    sclk_pe = 1'b1;
    @(negedge clk);
    m  = miso;
    oe = miso_oe;
    tick();
    sclk_pe = 1'b0;
    repeat (3) tick();
  endtask

  // nbits < 16 aborts after that many rising edges; rst_at >= 0 pulses reset
  // just before bit rst_at is sent.
  task automatic run_frame(input logic [6:0] a, input logic rw, input logic [7:0] d,
                           input int nbits, input int extra, input int rst_at,
                           input string tag);
    logic [7:0] cmd, rx;
    logic       m, oe, bitv, oe_all;
    int         we0, done0, oe0, cons0, total;
    cmd    = {a, rw};
    rx     = '0;
    oe_all = 1'b1;
    we0    = we_tot;
    done0  = done_tot;
    oe0    = oe_tot;
    cons0  = consec_tot;
    total  = (nbits < 16) ? nbits : 16 + extra;
    cs_n   = 1'b0;
    tick();
    tick();
    for (int i = 0; i < total; i++) begin
      if (i == rst_at) begin
        check_eq({tag, "_pre_miso"}, 32'(miso), 32'(exp_mem[a][7]));
        #2 rst_n = 1'b0;
        #1;
        check_eq({tag, "_rst_oe"}, 32'(miso_oe), 32'd0);
        check_eq({tag, "_rst_miso"}, 32'(miso), 32'd0);
        check_eq({tag, "_rst_addr"}, 32'(mem_addr), 32'd0);
        cs_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq({tag, "_rst_we"}, 32'(we_tot - we0), 32'd0);
        return;
      end
      if (i < 8) bitv = cmd[7-i];
      else if (i < 16) bitv = d[15-i];
      else bitv = 1'($urandom_range(0, 1));
      send_bit(bitv, m, oe);
      if (i >= 8 && i < 16) begin
        rx[15-i] = m;
        if (!oe) oe_all = 1'b0;
      end
    end
    if (nbits >= 16) begin
      if (rw) begin
        check_eq({tag, "_rdata"}, 32'(rx), 32'(exp_mem[a]));
        check_eq({tag, "_addr"}, 32'(mem_addr), 32'(a));
        check_eq({tag, "_oe_during"}, 32'(oe_all), 32'd1);
        check_eq({tag, "_oe_after"}, 32'(miso_oe), 32'd0);
        check_eq({tag, "_we_cnt"}, 32'(we_tot - we0), 32'd0);
      end else begin
        check_eq({tag, "_we_cnt"}, 32'(we_tot - we0), 32'd1);
        check_eq({tag, "_we_addr"}, 32'(we_addr), 32'(a));
        check_eq({tag, "_we_data"}, 32'(we_data), 32'(d));
        check_eq({tag, "_oe_cnt"}, 32'(oe_tot - oe0), 32'd0);
        exp_mem[a] = d;
      end
      check_eq({tag, "_done_cnt"}, 32'(done_tot - done0), 32'd1);
      check_eq({tag, "_consec"}, 32'(consec_tot - cons0), 32'd0);
    end else begin
      check_eq({tag, "_abort_we"}, 32'(we_tot - we0), 32'd0);
      check_eq({tag, "_abort_done"}, 32'(done_tot - done0), 32'd0);
    end
    cs_n = 1'b1;
    tick();
    check_eq({tag, "_idle_oe"}, 32'(miso_oe), 32'd0);
  endtask

  initial begin
    logic [6:0] ra;
    logic [7:0] rd;
    logic       rrw;
    int         rn;
    rst_n   = 1'b0;
    cs_n    = 1'b1;
    sclk_pe = 1'b0;
    sclk_ne = 1'b0;
    mosi    = 1'b0;
    pl_en   = 1'b1;
    for (int i = 0; i < 128; i++) begin
      exp_mem[i] = (i == 'h15) ? 8'hA5 : 8'($urandom);
      pl_addr    = 7'(i);
      pl_data    = exp_mem[i];
      tick();
    end
    pl_en = 1'b0;
    check_eq("reset_miso", 32'(miso), 32'd0);
    check_eq("reset_oe", 32'(miso_oe), 32'd0);
    check_eq("reset_we", 32'(mem_we), 32'd0);
    check_eq("reset_done", 32'(xfer_done), 32'd0);
    check_eq("reset_addr", 32'(mem_addr), 32'd0);
    check_eq("reset_wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    run_frame(7'h2A, 1'b0, 8'hC3, 16, 0, -1, "wr");
    run_frame(7'h15, 1'b1, 8'h00, 16, 0, -1, "rd");
    run_frame(7'h2A, 1'b0, 8'h3C, 12, 0, -1, "abort");
    run_frame(7'h01, 1'b0, 8'h5A, 16, 0, -1, "wr_after_abort");
    run_frame(7'h15, 1'b1, 8'h00, 16, 0, 9, "rst_rd");
    run_frame(7'h7F, 1'b0, 8'hFF, 16, 5, -1, "extra");
    run_frame(7'h03, 1'b0, 8'h11, 16, 0, -1, "b2b_wr");
    run_frame(7'h03, 1'b1, 8'h00, 16, 0, -1, "b2b_rd");
    run_frame(7'h2A, 1'b1, 8'h00, 16, 0, -1, "rd_back");

    for (int k = 0; k < 30; k++) begin
      ra  = 7'($urandom);
      rd  = 8'($urandom);
      rrw = 1'($urandom_range(0, 1));
      rn  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 15) : 16;
      run_frame(ra, rrw, rd, rn, $urandom_range(0, 2), -1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
